uart_tx_serializer: RTL and testbench

//  UART transmit serializer: accepts one parallel byte per start strobe and drives it onto the serial line.

---
 rtl/uart_tx_serializer_if.sv | 28 ++
 rtl/uart_tx_serializer.sv | 158 +++++++++++++++
 tb/tb_uart_tx_serializer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_serializer_if.sv
// Strobe/line bundle between a byte producer and the UART transmit serializer.
// master: producer side (drives start/data, observes line and status).
// slave : serializer side.
interface uart_tx_serializer_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_tx_start;
  logic [DATA_BITS-1:0] i_tx_data;
  logic                 o_tx;
  logic                 o_tx_busy;
  logic                 o_tx_done;

  modport master (
    output i_tx_start,
    output i_tx_data,
    input  o_tx,
    input  o_tx_busy,
    input  o_tx_done
  );

  modport slave (
    input  i_tx_start,
    input  i_tx_data,
    output o_tx,
    output o_tx_busy,
    output o_tx_done
  );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, DATA_BITS data bits LSB first,
// optional even parity bit, STOP_BITS stop bits. Every bit is held for
// CLK_FREQ_HZ/BAUD_RATE clock cycles. All outputs come straight from flops.
// Optional feature: define UART_TX_PARITY_EN to insert an even parity bit
// between the data bits and the stop bits.
module uart_tx_serializer #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1
) (
  input  logic                 i_clk,
  input  logic                 i_areset,
  uart_tx_serializer_if.slave  bus
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  // The stop phase is timed by the same counter, so size it for the longest phase.
  localparam int STOP_CLKS    = STOP_BITS * CLKS_PER_BIT;
  localparam int CNT_W        = $clog2(STOP_CLKS + 1);
  localparam int IDX_W        = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;
`endif

  state_t               state_reg;
  logic [CNT_W-1:0]     baud_cnt_reg;
  logic [IDX_W-1:0]     bit_idx_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 tx_reg;
  logic                 tx_busy_reg;
  logic                 tx_done_reg;
`ifdef UART_TX_PARITY_EN
  logic                 parity_reg;
`endif

  // Frame sequencer: every output is updated together with the state, so the
  // line changes only on clock edges and never glitches.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      state_reg    <= ST_IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
      tx_busy_reg  <= 1'b0;
      tx_done_reg  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      tx_done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // Accepting edge: the start bit goes out on this very edge.
          if (bus.i_tx_start) begin
            shift_reg    <= bus.i_tx_data;
`ifdef UART_TX_PARITY_EN
            parity_reg   <= ^bus.i_tx_data;
`endif
            tx_reg       <= 1'b0;
            tx_busy_reg  <= 1'b1;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            state_reg    <= ST_START;
          end
        end

        ST_START: begin
          if (baud_cnt_reg == BIT_LAST) begin
            baud_cnt_reg <= '0;
            tx_reg       <= shift_reg[0];
            shift_reg    <= shift_reg >> 1;
            state_reg    <= ST_DATA;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end

        ST_DATA: begin
          if (baud_cnt_reg == BIT_LAST) begin
            baud_cnt_reg <= '0;
            if (bit_idx_reg == IDX_LAST) begin
              bit_idx_reg <= '0;
`ifdef UART_TX_PARITY_EN
              tx_reg      <= parity_reg;
              state_reg   <= ST_PARITY;
`else
              tx_reg      <= 1'b1;
              state_reg   <= ST_STOP;
`endif
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
              tx_reg      <= shift_reg[0];
              shift_reg   <= shift_reg >> 1;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (baud_cnt_reg == BIT_LAST) begin
            baud_cnt_reg <= '0;
            tx_reg       <= 1'b1;
            state_reg    <= ST_STOP;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
`endif

        ST_STOP: begin
          // All stop bits are timed as one long phase; the done cycle is IDLE.
          if (baud_cnt_reg == STOP_LAST) begin
            baud_cnt_reg <= '0;
            tx_busy_reg  <= 1'b0;
            tx_done_reg  <= 1'b1;
            state_reg    <= ST_IDLE;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end

        default: begin
          baud_cnt_reg <= '0;
          tx_reg       <= 1'b1;
          tx_busy_reg  <= 1'b0;
          state_reg    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_tx      = tx_reg;
  assign bus.o_tx_busy = tx_busy_reg;
  assign bus.o_tx_done = tx_done_reg;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer at CLKS_PER_BIT=10, 8 data bits,
// 1 stop bit. Inputs are driven and outputs sampled on the falling edge.
module tb_uart_tx_serializer;

  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic i_clk = 1'b0;
  logic i_areset = 1'b1;
  int   total = 0;
  int   bad = 0;

  // Simple receiver model state
  bit         rx_en = 1'b0;
  logic [7:0] rx_q[$];
  int         rx_done_cnt = 0;
  int         rx_stop_err = 0;

  uart_tx_serializer_if #(.DATA_BITS(8)) bus ();

  uart_tx_serializer #(
    .CLK_FREQ_HZ(1_000_000),
    .BAUD_RATE  (100_000),
    .DATA_BITS  (8),
    .STOP_BITS  (1)
  ) dut (
    .i_clk   (i_clk),
    .i_areset(i_areset),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  // Expected line level for each bit slot of a frame carrying d
  function automatic logic [10:0] frame_bits(input logic [7:0] d);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
`ifdef UART_TX_PARITY_EN
    f[9] = ^d;
`endif
    return f;
  endfunction

  // Receiver: detect start low, sample each bit at its middle
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge i_clk);
      if (rx_en && bus.o_tx === 1'b0) begin
        repeat (CPB / 2) @(negedge i_clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge i_clk);
          b[i] = bus.o_tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge i_clk);
`endif
        repeat (CPB) @(negedge i_clk);
        if (bus.o_tx !== 1'b1) rx_stop_err++;
        rx_q.push_back(b);
        rx_done_cnt++;
      end
    end
  end

  task automatic launch(input logic [7:0] d);
    @(negedge i_clk);
    bus.i_tx_start = 1'b1;
    bus.i_tx_data  = d;
  endtask

  // Start must already be asserted; checks every cycle of the frame.
  task automatic check_frame(input logic [7:0] d, input int poke_k,
                             input bit chain, input logic [7:0] next_d,
                             input string name);
    logic [10:0] fb;
    logic        exp_tx;
    fb = frame_bits(d);
    @(posedge i_clk);
    for (int k = 0; k < NB * CPB; k++) begin
      @(negedge i_clk);
      exp_tx = fb[k / CPB];
      total++;
      if (bus.o_tx !== exp_tx) begin
        bad++;
        $display("FAIL %s tx k=%0d: got %b want %b", name, k, bus.o_tx, exp_tx);
      end
      total++;
      if (bus.o_tx_busy !== 1'b1) begin
        bad++;
        $display("FAIL %s busy k=%0d: got %b want 1", name, k, bus.o_tx_busy);
      end
      total++;
      if (bus.o_tx_done !== 1'b0) begin
        bad++;
        $display("FAIL %s done k=%0d: got %b want 0", name, k, bus.o_tx_done);
      end
      if (k == 0) begin
        bus.i_tx_start = 1'b0;
        bus.i_tx_data  = ~d;
      end
      if (k == poke_k) begin
        bus.i_tx_start = 1'b1;
        bus.i_tx_data  = 8'hFF;
      end else if (k == poke_k + 1) begin
        bus.i_tx_start = 1'b0;
      end
    end
    @(negedge i_clk);
    total++;
    if (bus.o_tx !== 1'b1 || bus.o_tx_busy !== 1'b0 || bus.o_tx_done !== 1'b1) begin
      bad++;
      $display("FAIL %s end: tx/busy/done got %b%b%b want 101", name,
               bus.o_tx, bus.o_tx_busy, bus.o_tx_done);
    end
    if (chain) begin
      bus.i_tx_start = 1'b1;
      bus.i_tx_data  = next_d;
    end else begin
      bus.i_tx_start = 1'b0;
      @(negedge i_clk);
      total++;
      if (bus.o_tx !== 1'b1 || bus.o_tx_busy !== 1'b0 || bus.o_tx_done !== 1'b0) begin
        bad++;
        $display("FAIL %s after: tx/busy/done got %b%b%b want 100", name,
                 bus.o_tx, bus.o_tx_busy, bus.o_tx_done);
      end
    end
  endtask

  task automatic test_reset();
    bus.i_tx_start = 1'b0;
    bus.i_tx_data  = 8'h00;
    i_areset = 1'b1;
    repeat (3) @(negedge i_clk);
    i_areset = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge i_clk);
      total++;
      if (bus.o_tx !== 1'b1 || bus.o_tx_busy !== 1'b0 || bus.o_tx_done !== 1'b0) begin
        bad++;
        $display("FAIL reset idle c=%0d: tx/busy/done got %b%b%b want 100", c,
                 bus.o_tx, bus.o_tx_busy, bus.o_tx_done);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_frame_a5();
    launch(8'hA5);
    check_frame(8'hA5, -1, 1'b0, 8'h00, "frame_a5");
    $display("test_frame_a5 done");
  endtask

  task automatic test_frame_07();
    launch(8'h07);
    check_frame(8'h07, -1, 1'b0, 8'h00, "frame_07");
    $display("test_frame_07 done");
  endtask

  task automatic test_back_to_back();
    launch(8'h3C);
    check_frame(8'h3C, 40, 1'b1, 8'h81, "busy_ignore_3c");
    check_frame(8'h81, -1, 1'b0, 8'h00, "back_to_back_81");
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid();
    logic [10:0] fb;
    fb = frame_bits(8'h55);
    launch(8'h55);
    @(posedge i_clk);
    for (int k = 0; k < 35; k++) begin
      @(negedge i_clk);
      if (k == 0) bus.i_tx_start = 1'b0;
      total++;
      if (bus.o_tx !== fb[k / CPB]) begin
        bad++;
        $display("FAIL reset_mid pre k=%0d: tx got %b want %b", k, bus.o_tx, fb[k / CPB]);
      end
    end
    @(negedge i_clk);
    i_areset = 1'b1;
    #1;
    total++;
    if (bus.o_tx !== 1'b1 || bus.o_tx_busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid async: tx/busy got %b%b want 10", bus.o_tx, bus.o_tx_busy);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      total++;
      if (bus.o_tx !== 1'b1 || bus.o_tx_busy !== 1'b0 || bus.o_tx_done !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid hold c=%0d: tx/busy/done got %b%b%b want 100", c,
                 bus.o_tx, bus.o_tx_busy, bus.o_tx_done);
      end
    end
    i_areset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      total++;
      if (bus.o_tx !== 1'b1 || bus.o_tx_busy !== 1'b0 || bus.o_tx_done !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid post c=%0d: tx/busy/done got %b%b%b want 100", c,
                 bus.o_tx, bus.o_tx_busy, bus.o_tx_done);
      end
    end
    launch(8'h55);
    check_frame(8'h55, -1, 1'b0, 8'h00, "reset_mid_55");
    $display("test_reset_mid done");
  endtask

  task automatic test_loopback();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h00;
    exp_b[1] = 8'hFF;
    exp_b[2] = 8'hA5;
    exp_b[3] = 8'h5A;
    rx_q.delete();
    rx_done_cnt = 0;
    rx_stop_err = 0;
    rx_en = 1'b1;
    launch(8'h00);
    check_frame(8'h00, -1, 1'b1, 8'hFF, "loop_00");
    check_frame(8'hFF, -1, 1'b1, 8'hA5, "loop_ff");
    check_frame(8'hA5, -1, 1'b1, 8'h5A, "loop_a5");
    check_frame(8'h5A, -1, 1'b0, 8'h00, "loop_5a");
    repeat (5) @(negedge i_clk);
    rx_en = 1'b0;
    total++;
    if (rx_done_cnt !== 4) begin
      bad++;
      $display("FAIL loopback rx_done count: got %0d want 4", rx_done_cnt);
    end
    total++;
    if (rx_stop_err !== 0) begin
      bad++;
      $display("FAIL loopback stop bits: got %0d errors want 0", rx_stop_err);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (i >= rx_q.size()) begin
        bad++;
        $display("FAIL loopback byte %0d: got none want %h", i, exp_b[i]);
      end else if (rx_q[i] !== exp_b[i]) begin
        bad++;
        $display("FAIL loopback byte %0d: got %h want %h", i, rx_q[i], exp_b[i]);
      end else begin
        $display("loopback byte %0d = %h", i, rx_q[i]);
      end
    end
    $display("test_loopback done");
  endtask

  initial begin
    bus.i_tx_start = 1'b0;
    bus.i_tx_data  = 8'h00;
    test_reset();
    test_frame_a5();
    test_frame_07();
    test_back_to_back();
    test_reset_mid();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
